// File: rtl/pulse_train_if.sv
// Control/status bundle for pulse_train_generator: a start request with its
// train configuration going in, the generated waveform and train status coming out.
interface pulse_train_if #(
  parameter int CNT_W = 8,
  parameter int NUM_W = 8
);
  // Handshake: a request is start=1 sampled while busy=0. Every request is
  // answered by exactly one done pulse. start and the configuration are
  // ignored while busy=1. A request made during the done cycle is accepted.
  logic             start;
  logic [CNT_W-1:0] high_cycles;
  logic [CNT_W-1:0] low_cycles;
  logic [NUM_W-1:0] num_pulses;
  logic             signal;
  logic             busy;
  logic             done;
  logic [NUM_W-1:0] pulses_sent;
  logic [1:0]       state_dbg;

  modport master (
    output start, high_cycles, low_cycles, num_pulses,
    input  signal, busy, done, pulses_sent, state_dbg
  );

  modport slave (
    input  start, high_cycles, low_cycles, num_pulses,
    output signal, busy, done, pulses_sent, state_dbg
  );
endinterface

// File: rtl/pulse_train_generator.sv
// Programmable pulse-train source: on start, emits N pulses of H clocks high and
// L clocks low back to back, then strobes done. All outputs are flop outputs.
module pulse_train_generator #(
  parameter int CNT_W = 8,
  parameter int NUM_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  pulse_train_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] h_lat;
  logic [CNT_W-1:0] l_lat;
  logic [NUM_W-1:0] n_lat;
  logic             signal_q;
  logic             busy_q;
  logic             done_q;
  logic [NUM_W-1:0] pulses_q;

  // The counter runs 1..limit and stops at the latched limit, so a limit of
  // all ones never needs a value past the counter's range.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      phase_cnt <= '0;
      h_lat     <= '0;
      l_lat     <= '0;
      n_lat     <= '0;
      signal_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pulses_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.num_pulses != '0) begin
              h_lat     <= (bus.high_cycles == '0) ? CNT_W'(1) : bus.high_cycles;
              l_lat     <= (bus.low_cycles == '0) ? CNT_W'(1) : bus.low_cycles;
              n_lat     <= bus.num_pulses;
              state     <= HIGH;
              signal_q  <= 1'b1;
              busy_q    <= 1'b1;
              pulses_q  <= NUM_W'(1);
              phase_cnt <= CNT_W'(1);
            end else begin
              // Zero-length request completes immediately without a train.
              done_q   <= 1'b1;
              pulses_q <= '0;
            end
          end
        end
        HIGH: begin
          if (phase_cnt == h_lat) begin
            state     <= LOW;
            signal_q  <= 1'b0;
            phase_cnt <= CNT_W'(1);
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        LOW: begin
          if (phase_cnt == l_lat) begin
            if (pulses_q != n_lat) begin
              state     <= HIGH;
              signal_q  <= 1'b1;
              pulses_q  <= pulses_q + NUM_W'(1);
              phase_cnt <= CNT_W'(1);
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          signal_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.signal      = signal_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pulses_sent = pulses_q;
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Bench for pulse_train_generator: directed and randomized trains on an 8-bit and
// a 4-bit counter instance, checked cycle by cycle against a waveform model.
module tb_pulse_train_generator;
  localparam int NUM_W = 8;
  localparam int EW    = NUM_W + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pulse_train_if #(.CNT_W(8), .NUM_W(NUM_W)) bus_a ();
  pulse_train_if #(.CNT_W(4), .NUM_W(NUM_W)) bus_b ();

  pulse_train_generator #(.CNT_W(8), .NUM_W(NUM_W)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  pulse_train_generator #(.CNT_W(4), .NUM_W(NUM_W)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  // ---------------- scoreboard state ----------------
  // Entry layout: {signal, busy, done, pulses_sent}
  logic [EW-1:0]    exp_q[$];
  logic [NUM_W-1:0] last_ps [2];
  int               checks;
  int               errors;
  int               edge_cnt;
  int               busy_cnt;
  logic             prev_sig;

  function automatic logic [EW-1:0] obs(input bit sel);
    if (sel) return {bus_b.signal, bus_b.busy, bus_b.done, bus_b.pulses_sent};
    return {bus_a.signal, bus_a.busy, bus_a.done, bus_a.pulses_sent};
  endfunction

  // Reference waveform: each pulse is max(H,1) high cycles then max(L,1) low
  // cycles with pulses_sent equal to the pulse number, then one done cycle.
  task automatic model_train(input bit sel, input int h, input int l, input int n);
    int hh;
    int ll;
    hh = (h == 0) ? 1 : h;
    ll = (l == 0) ? 1 : l;
    if (n == 0) begin
      exp_q.push_back({1'b0, 1'b0, 1'b1, NUM_W'(0)});
      last_ps[sel] = '0;
    end else begin
      for (int p = 1; p <= n; p++) begin
        for (int i = 0; i < hh; i++) exp_q.push_back({1'b1, 1'b1, 1'b0, NUM_W'(p)});
        for (int i = 0; i < ll; i++) exp_q.push_back({1'b0, 1'b1, 1'b0, NUM_W'(p)});
      end
      exp_q.push_back({1'b0, 1'b0, 1'b1, NUM_W'(n)});
      last_ps[sel] = NUM_W'(n);
    end
  endtask

  task automatic check_next(input bit sel, input string tag);
    logic [EW-1:0] exp_v;
    logic [EW-1:0] got;
    exp_v = exp_q.pop_front();
    got   = obs(sel);
    checks++;
    assert (got === exp_v) else begin
      errors++;
      $error("FAIL %s: observed sig/busy/done/ps=%b/%b/%b/%0d expected %b/%b/%b/%0d",
             tag, got[EW-1], got[EW-2], got[EW-3], got[NUM_W-1:0],
             exp_v[EW-1], exp_v[EW-2], exp_v[EW-3], exp_v[NUM_W-1:0]);
    end
    if (!sel) begin
      if (got[EW-1] && !prev_sig) edge_cnt++;
      prev_sig = got[EW-1];
      if (got[EW-2]) busy_cnt++;
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp_v);
    checks++;
    assert (got === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit sel, input bit st, input int h, input int l, input int n);
    logic [31:0] hv;
    logic [31:0] lv;
    logic [31:0] nv;
    hv = h;
    lv = l;
    nv = n;
    if (sel) begin
      bus_b.start       = st;
      bus_b.high_cycles = hv[3:0];
      bus_b.low_cycles  = lv[3:0];
      bus_b.num_pulses  = nv[NUM_W-1:0];
    end else begin
      bus_a.start       = st;
      bus_a.high_cycles = hv[7:0];
      bus_a.low_cycles  = lv[7:0];
      bus_a.num_pulses  = nv[NUM_W-1:0];
    end
  endtask

  task automatic idle_cycles(input bit sel, input int k, input string tag);
    for (int i = 0; i < k; i++) begin
      exp_q.push_back({1'b0, 1'b0, 1'b0, last_ps[sel]});
      @(negedge clk);
      check_next(sel, tag);
    end
  endtask

  // mode 0: start low while busy; 1: random start/config while busy;
  // 2: start held high while busy. start is always low on the done cycle
  // unless the caller immediately issues the next request.
  task automatic run_train(input bit sel, input int h, input int l, input int n,
                           input int mode, input string tag);
    bit nb;
    drive(sel, 1'b1, h, l, n);
    model_train(sel, h, l, n);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      nb = exp_q[0][EW-2];
      check_next(sel, tag);
      if (nb && mode == 1)
        drive(sel, 1'($urandom_range(0, 1)), $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 255));
      else if (nb && mode == 2)
        drive(sel, 1'b1, h, l, n);
      else
        drive(sel, 1'b0, h, l, n);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks     = 0;
    errors     = 0;
    edge_cnt   = 0;
    busy_cnt   = 0;
    prev_sig   = 1'b0;
    last_ps[0] = '0;
    last_ps[1] = '0;
    reset      = 1'b1;
    drive(1'b0, 1'b0, 0, 0, 0);
    drive(1'b1, 1'b0, 0, 0, 0);
    repeat (4) @(negedge clk);

    exp_q.push_back({1'b0, 1'b0, 1'b0, NUM_W'(0)});
    check_next(1'b0, "reset_a");
    exp_q.push_back({1'b0, 1'b0, 1'b0, NUM_W'(0)});
    check_next(1'b1, "reset_b");
    reset = 1'b0;

    busy_cnt = 0;
    run_train(1'b0, 4, 4, 3, 0, "basic");
    check_int("basic_busy_cycles", busy_cnt, 24);
    idle_cycles(1'b0, 2, "basic_idle");

    run_train(1'b0, 0, 0, 2, 0, "clamp");
    idle_cycles(1'b0, 1, "clamp_idle");
    busy_cnt = 0;
    run_train(1'b0, 5, 5, 0, 0, "zero_len");
    idle_cycles(1'b0, 2, "zero_idle");
    check_int("zero_busy_cycles", busy_cnt, 0);

    busy_cnt = 0;
    run_train(1'b0, 2, 3, 4, 1, "ignore_busy");
    check_int("ignore_busy_cycles", busy_cnt, 20);
    idle_cycles(1'b0, 1, "ignore_idle");

    edge_cnt = 0;
    prev_sig = 1'b0;
    run_train(1'b0, 1, 1, 2, 2, "b2b_first");
    run_train(1'b0, 1, 1, 2, 2, "b2b_second");
    idle_cycles(1'b0, 2, "b2b_idle");
    check_int("b2b_rising_edges", edge_cnt, 4);

    // Reset lands on the 12th edge after the start is accepted.
    drive(1'b0, 1'b1, 5, 5, 4);
    model_train(1'b0, 5, 5, 4);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check_next(1'b0, "pre_reset");
      drive(1'b0, 1'b0, 5, 5, 4);
    end
    reset = 1'b1;
    exp_q.delete();
    last_ps[0] = '0;
    last_ps[1] = '0;
    exp_q.push_back({1'b0, 1'b0, 1'b0, NUM_W'(0)});
    @(negedge clk);
    check_next(1'b0, "mid_reset");
    reset = 1'b0;
    idle_cycles(1'b0, 4, "post_reset_no_done");

    run_train(1'b1, 15, 15, 1, 0, "max_width");
    idle_cycles(1'b1, 2, "max_idle");
    run_train(1'b1, 0, 3, 2, 1, "narrow_clamp");
    idle_cycles(1'b1, 1, "narrow_idle");

    for (int t = 0; t < 10; t++) begin
      run_train(1'b0, $urandom_range(0, 6), $urandom_range(0, 6),
                $urandom_range(0, 4), 1, "random_train");
      idle_cycles(1'b0, $urandom_range(0, 2), "random_idle");
    end

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_train_generator.md
# pulse_train_generator

Programmable pulse-train source that drives the `signal` input of the rising-edge detector. On a `start` strobe it emits N pulses, each HIGH_CYCLES clocks high followed by LOW_CYCLES clocks low, then reports completion. It replaces hand-written `#40` stimulus sequences in benches and supplies on-chip test patterns to edge and pulse logic.

## Interface
- `CNT_W`, 8: width of `high_cycles` and `low_cycles`, and of the phase counter.
- `NUM_W`, 8: width of `num_pulses` and `pulses_sent`.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset; one clock, no other clock domains.
- `start`  in  1  request strobe, sampled only in IDLE.
- `high_cycles`  in  CNT_W  high-phase length in clocks; 0 treated as 1.
- `low_cycles`  in  CNT_W  low-phase length in clocks; 0 treated as 1.
- `num_pulses`  in  NUM_W  number of pulses; 0 means no pulses.
- `signal`  out  1  generated waveform, registered, glitch-free.
- `busy`  out  1  high while a train is in progress.
- `done`  out  1  single-cycle completion strobe.
- `pulses_sent`  out  NUM_W  rising edges emitted in the current or last train.

## Operation
- States: IDLE, HIGH, LOW.
- Reset: on a clock edge with `reset`=1, state goes to IDLE, and `signal`, `busy`, `done` and `pulses_sent` all go to 0. Reset has priority over every other input, including mid-train; no partial pulse continues.
- **IDLE**
  - `start`=1 and `num_pulses`≠0: latch H = max(`high_cycles`,1), L = max(`low_cycles`,1) and N = `num_pulses`. Go to HIGH with `signal`=1, `busy`=1, `pulses_sent`=1 and phase counter = 1.
  - `start`=1 and `num_pulses`=0: stay in IDLE. `done`=1 for one cycle, `busy` stays 0, `signal` stays 0, `pulses_sent`=0.
  - Otherwise hold.
- **HIGH**
  - When the phase counter = H: go to LOW with `signal`=0 and counter = 1.
  - Otherwise increment the counter.
- **LOW**
  - When counter = L and `pulses_sent` < N: go to HIGH with `signal`=1, `pulses_sent`+1 and counter = 1.
  - When counter = L and `pulses_sent` = N: go to IDLE with `busy`=0 and `done`=1 for one cycle.
  - Otherwise increment the counter.
- `start` and all configuration inputs are ignored while `busy`=1. Changes to configuration inputs mid-train have no effect.
- `done` is asserted only on the cycle after the train finishes (or on a zero-length request). It is deasserted on the following edge.
- `pulses_sent` holds its final value (N) in IDLE until the next accepted `start` or `reset`. It never wraps, since N ≤ 2^NUM_W−1.
- Counters compare against the latched H and L. Maximum values (2^CNT_W−1) must count fully without overflow.

## Timing
- Start latency: if `start` is sampled at edge k, `signal`=1 and `busy`=1 are visible after edge k.
- Each pulse is exactly H cycles high followed by exactly L cycles low. There is no gap between pulses.
- `busy` is high for exactly N·(H+L) cycles.
- `done` is high for the one cycle immediately after `busy` falls.
- Back-to-back trains: `start`=1 during the `done` cycle is accepted at that cycle's edge. `signal` rises again after exactly L low cycles plus the one `done` cycle.
- Every output is a flop output. `signal` has no combinational path from any input.

## Test plan
- **Basic train:** reset 4 cycles, then `start` with H=4, L=4, N=3 (100 MHz, matching the 40 ns stimulus pattern).
  - `signal` must be 1,1,1,1,0,0,0,0 repeated three times.
  - `busy` high for 24 cycles; `done` high for 1 cycle on cycle 25.
  - `pulses_sent`=3 at the end.
- **Clamp and zero:**
  - H=0, L=0, N=2 → waveform 1,0,1,0, then `done`.
  - N=0 → `done` on the next cycle, `busy` never asserted, `signal` stays 0.
- **Ignore while busy:** H=2, L=3, N=4. Pulse `start` and change H to 7 at cycle 5 → the train is unchanged (20 busy cycles, all pulses 2 high / 3 low).
- **Reset mid-train:** H=5, L=5, N=4, assert `reset` at cycle 12 → after that edge `signal`=0, `busy`=0, `done`=0 and `pulses_sent`=0. No `done` pulse follows.
- **Back-to-back:** H=1, L=1, N=2, with `start` held high through the `done` cycle → a second train starts; exactly one idle low cycle separates the two trains. An edge detector on `signal` must count 4 rising edges total.
- **Max width:** CNT_W=4 with H=15, L=15, N=1 → exactly 15 high and 15 low cycles, with no counter wrap.
